// File: rtl/mesi_pkg.sv
// mesi_pkg: MESI encodings, bus field positions and snoop FSM states shared by the snoop responder and bus controller
package mesi_pkg;
  typedef enum logic [1:0] {MESI_I = 2'b00, MESI_S = 2'b01, MESI_E = 2'b10, MESI_M = 2'b11} mesi_t;
  localparam int BUS_ID_HI = 4;
  localparam int BUS_ID_LO = 3;
  localparam int BUS_RD    = 2;
  localparam int BUS_RDX   = 1;
  localparam int BUS_UPGR  = 0;
  typedef enum logic [1:0] {ST_IDLE, ST_LOOKUP, ST_FLUSH, ST_DONE} snoop_fsm_t;
endpackage

// File: rtl/mesi_snoop_responder_if.sv
// mesi_snoop_responder_if: snoop request/response and memory flush handshake of one core's snoop responder
interface mesi_snoop_responder_if #(parameter int INDEX_W = 4);
  logic               snoop_valid;
  logic               snoop_ready;
  logic [4:0]         bus_signals;
  logic [INDEX_W-1:0] snoop_index;
  logic               snoop_hit;
  logic               shared_out;
  logic               snoop_done;
  logic               flush_req;
  logic [INDEX_W-1:0] flush_index;
  logic               flush_ack;
  modport master (
    output snoop_valid, bus_signals, snoop_index, snoop_hit, flush_ack,
    input  snoop_ready, shared_out, snoop_done, flush_req, flush_index
  );
  modport slave (
    input  snoop_valid, bus_signals, snoop_index, snoop_hit, flush_ack,
    output snoop_ready, shared_out, snoop_done, flush_req, flush_index
  );
endinterface

// File: rtl/mesi_state_table.sv
// mesi_state_table: per-line MESI register file, one local read, one snoop read, snoop write beats local write
module mesi_state_table import mesi_pkg::*; #(
  parameter int INDEX_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] rd_index_i,
  output logic [1:0]         rd_state_o,
  input  logic [INDEX_W-1:0] snp_index_i,
  output logic [1:0]         snp_state_o,
  input  logic               snp_we_i,
  input  logic [1:0]         snp_state_i,
  input  logic               loc_we_i,
  input  logic [INDEX_W-1:0] loc_index_i,
  input  logic [1:0]         loc_state_i
);
  localparam int DEPTH = 2 ** INDEX_W;
  logic [1:0] mem_q [DEPTH];
  assign rd_state_o  = mem_q[rd_index_i];
  assign snp_state_o = mem_q[snp_index_i];
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    always_ff @(posedge clk)
      mem_q[i] <= rst                                           ? MESI_I      :
                  (snp_we_i && snp_index_i == INDEX_W'(i))      ? snp_state_i :
                  (loc_we_i && loc_index_i == INDEX_W'(i))      ? loc_state_i : mem_q[i];
  end
endmodule

// File: rtl/mesi_snoop_responder.sv
// mesi_snoop_responder: snoop side of one core on the 4-core MESI bus, owns the core's MESI state table
module mesi_snoop_responder import mesi_pkg::*; #(
  parameter int CORE_ID = 0,
  parameter int INDEX_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  mesi_snoop_responder_if.slave sif,
  input  logic                loc_upd_valid,
  input  logic [INDEX_W-1:0]  loc_upd_index,
  input  logic [1:0]          loc_upd_state,
  input  logic [INDEX_W-1:0]  rd_index,
  output logic [1:0]          rd_state,
  output logic                protocol_err
);
  snoop_fsm_t         state_q, state_d;
  logic [4:0]         bus_q, bus_d;
  logic [INDEX_W-1:0] idx_q, idx_d;
  logic               hit_q, hit_d;
  logic [1:0]         next_q, next_d;
  logic               shared_q, shared_d;
  logic               perr_q, perr_d;
  logic [1:0]         cur;
  logic [2:0]         cmd;
  logic               own, multi, act;
  logic               snp_we;
  logic [1:0]         snp_wstate;
  assign cmd   = bus_q[BUS_RD:BUS_UPGR];
  assign own   = bus_q[BUS_ID_HI:BUS_ID_LO] == 2'(CORE_ID);
  assign multi = (cmd & (cmd - 3'd1)) != 3'd0;
  // act: a single-command foreign snoop that hits a valid local copy
  assign act   = !own && cmd != 3'd0 && !multi && hit_q && cur != MESI_I;
  always_comb begin
    state_d  = state_q;
    bus_d    = bus_q;
    idx_d    = idx_q;
    hit_d    = hit_q;
    next_d   = next_q;
    shared_d = shared_q;
    perr_d   = perr_q;
    case (state_q)
      ST_IDLE: if (sif.snoop_valid) begin
        bus_d   = sif.bus_signals;
        idx_d   = sif.snoop_index;
        hit_d   = sif.snoop_hit;
        state_d = ST_LOOKUP;
      end
      ST_LOOKUP: begin
        shared_d = act;
        next_d   = cmd[BUS_RD] ? MESI_S : MESI_I;
        perr_d   = perr_q | (!own && multi) | (act && cmd[BUS_UPGR] && cur != MESI_S);
        state_d  = (act && cur == MESI_M && !cmd[BUS_UPGR]) ? ST_FLUSH : ST_DONE;
      end
      ST_FLUSH: state_d = sif.flush_ack ? ST_DONE : ST_FLUSH;
      ST_DONE:  state_d = ST_IDLE;
    endcase
    snp_we     = (state_q == ST_LOOKUP && act && state_d == ST_DONE) || (state_q == ST_FLUSH && sif.flush_ack);
    snp_wstate = (state_q == ST_LOOKUP) ? next_d : next_q;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q  <= ST_IDLE;
      bus_q    <= '0;
      idx_q    <= '0;
      hit_q    <= 1'b0;
      next_q   <= MESI_I;
      shared_q <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bus_q    <= bus_d;
      idx_q    <= idx_d;
      hit_q    <= hit_d;
      next_q   <= next_d;
      shared_q <= shared_d;
      perr_q   <= perr_d;
    end
  assign sif.snoop_ready = state_q == ST_IDLE;
  assign sif.snoop_done  = state_q == ST_DONE;
  assign sif.shared_out  = shared_q;
  assign sif.flush_req   = state_q == ST_FLUSH;
  assign sif.flush_index = (state_q == ST_FLUSH) ? idx_q : '0;
  assign protocol_err    = perr_q;
  mesi_state_table #(.INDEX_W(INDEX_W)) u_table (
    .clk         (clk),
    .rst         (rst),
    .rd_index_i  (rd_index),
    .rd_state_o  (rd_state),
    .snp_index_i (idx_q),
    .snp_state_o (cur),
    .snp_we_i    (snp_we),
    .snp_state_i (snp_wstate),
    .loc_we_i    (loc_upd_valid),
    .loc_index_i (loc_upd_index),
    .loc_state_i (loc_upd_state)
  );
endmodule

// File: tb/tb_mesi_snoop_responder.sv
// tb_mesi_snoop_responder: vector table, corner sequences and random snoops against a rule-level MESI model
module tb_mesi_snoop_responder;
  localparam logic [1:0] CID = 2'd0;
  localparam logic [1:0] I = 2'b00, S = 2'b01, E = 2'b10, M = 2'b11;
  logic clk = 1'b0;
  logic rst;
  logic loc_upd_valid;
  logic [3:0] loc_upd_index, rd_index;
  logic [1:0] loc_upd_state, rd_state;
  logic protocol_err;
  int checks = 0, failures = 0;
  logic [1:0] model_tbl [16];
  logic exp_perr;
  int lat, fc, nz, n;
  logic sh;
  mesi_snoop_responder_if #(.INDEX_W(4)) sif ();
  mesi_snoop_responder #(.CORE_ID(0), .INDEX_W(4)) dut (
    .clk(clk), .rst(rst), .sif(sif),
    .loc_upd_valid(loc_upd_valid), .loc_upd_index(loc_upd_index), .loc_upd_state(loc_upd_state),
    .rd_index(rd_index), .rd_state(rd_state), .protocol_err(protocol_err)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [1:0] pre; logic [4:0] bus; logic [3:0] ix; logic hit; int dly;
    logic [1:0] nxt; logic sh; int fc; logic err;
  } vec_t;
  vec_t vt [11];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask
  // Snoop outcome straight from the coherence rules: next state, shared, flush needed, protocol error
  function automatic void ref_snoop(input logic [1:0] cur, input logic [4:0] b, input logic h,
                                    output logic [1:0] nxt, output logic shr, output logic fl, output logic er);
    int ncmd = $countones(b[2:0]);
    nxt = cur; shr = 0; fl = 0; er = 0;
    if (b[4:3] == CID || ncmd == 0) return;
    if (ncmd > 1) begin er = 1; return; end
    if (!h || cur == I) return;
    shr = 1;
    if (b[2]) begin nxt = S; fl = (cur == M); end
    else if (b[1]) begin nxt = I; fl = (cur == M); end
    else begin nxt = I; er = (cur != S); end
  endfunction
  task automatic set_state(input logic [3:0] ix, input logic [1:0] st);
    @(negedge clk);
    loc_upd_valid = 1; loc_upd_index = ix; loc_upd_state = st;
    @(negedge clk);
    loc_upd_valid = 0;
    model_tbl[ix] = st;
  endtask
  task automatic do_snoop(input logic [4:0] b, input logic [3:0] ix, input logic h, input int dly,
                          input int lcyc, input logic [3:0] lix, input logic [1:0] lst,
                          output int o_lat, output int o_fc, output logic o_sh);
    int k = 0, bad = 0;
    o_lat = -1; o_fc = 0; o_sh = 0;
    @(negedge clk);
    chk("ready_before_snoop", sif.snoop_ready, 1);
    sif.snoop_valid = 1; sif.bus_signals = b; sif.snoop_index = ix; sif.snoop_hit = h;
    @(posedge clk); #1;
    sif.snoop_valid = 0; sif.bus_signals = 5'($urandom); sif.snoop_index = 4'($urandom); sif.snoop_hit = 1'($urandom);
    while (o_lat < 0 && k < 40) begin
      @(negedge clk); k++;
      loc_upd_valid = (k == lcyc); loc_upd_index = lix; loc_upd_state = lst;
      if (sif.flush_req) begin o_fc++; if (sif.flush_index != ix) bad++; end
      sif.flush_ack = sif.flush_req && o_fc > dly;
      if (sif.snoop_done) begin o_lat = k; o_sh = sif.shared_out; end
    end
    loc_upd_valid = 0; sif.flush_ack = 0;
    chk("snoop_completed", o_lat >= 0, 1);
    chk("flush_index_held", bad, 0);
  endtask
  task automatic verify(input string nm, input logic [3:0] ix, input logic [1:0] e_nxt, input logic e_sh,
                        input int e_fc, input int a_lat, input int a_fc, input logic a_sh);
    chk({nm, "_latency"}, a_lat, e_fc > 0 ? 2 + e_fc : 2);
    chk({nm, "_shared"}, a_sh, e_sh);
    chk({nm, "_flush_cycles"}, a_fc, e_fc);
    rd_index = ix; #1;
    chk({nm, "_state"}, rd_state, e_nxt);
    chk({nm, "_perr"}, protocol_err, exp_perr);
    @(negedge clk);
    chk({nm, "_ready_after"}, sif.snoop_ready, 1);
    chk({nm, "_done_pulse"}, sif.snoop_done, 0);
  endtask
  initial begin
    rst = 1; loc_upd_valid = 0; loc_upd_index = 0; loc_upd_state = 0; rd_index = 0;
    sif.snoop_valid = 0; sif.bus_signals = 0; sif.snoop_index = 0; sif.snoop_hit = 0; sif.flush_ack = 0;
    exp_perr = 0;
    for (int k = 0; k < 16; k++) model_tbl[k] = I;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 0;
    chk("rst_ready", sif.snoop_ready, 1);
    chk("rst_done", sif.snoop_done, 0);
    chk("rst_shared", sif.shared_out, 0);
    chk("rst_flush_req", sif.flush_req, 0);
    chk("rst_flush_index", sif.flush_index, 0);
    chk("rst_perr", protocol_err, 0);
    for (int k = 0; k < 16; k++) begin
      rd_index = 4'(k); #1;
      chk($sformatf("rst_table%0d", k), rd_state, I);
    end
    vt[0]  = '{E, 5'b01100, 4'd3,  1, 0, S, 1, 0, 0};
    vt[1]  = '{M, 5'b10010, 4'd5,  1, 3, I, 1, 4, 0};
    vt[2]  = '{M, 5'b00100, 4'd2,  1, 0, M, 0, 0, 0};
    vt[3]  = '{S, 5'b01100, 4'd9,  0, 0, S, 0, 0, 0};
    vt[4]  = '{I, 5'b11010, 4'd1,  1, 0, I, 0, 0, 0};
    vt[5]  = '{M, 5'b11100, 4'd8,  1, 0, S, 1, 1, 0};
    vt[6]  = '{S, 5'b01001, 4'd10, 1, 0, I, 1, 0, 0};
    vt[7]  = '{E, 5'b10110, 4'd11, 1, 0, E, 0, 0, 1};
    vt[8]  = '{M, 5'b11001, 4'd7,  1, 0, I, 1, 0, 1};
    vt[9]  = '{E, 5'b11000, 4'd15, 1, 2, E, 0, 0, 0};
    vt[10] = '{E, 5'b01001, 4'd0,  1, 0, I, 1, 0, 1};
    for (int v = 0; v < 11; v++) begin
      set_state(vt[v].ix, vt[v].pre);
      do_snoop(vt[v].bus, vt[v].ix, vt[v].hit, vt[v].dly, 0, 0, 0, lat, fc, sh);
      exp_perr |= vt[v].err;
      verify($sformatf("vec%0d", v), vt[v].ix, vt[v].nxt, vt[v].sh, vt[v].fc, lat, fc, sh);
    end
    set_state(4, S); set_state(6, I);
    do_snoop(5'b01010, 4, 1, 0, 1, 6, E, lat, fc, sh);
    verify("rdx_other_upd", 4, I, 1, 0, lat, fc, sh);
    rd_index = 6; #1;
    chk("other_upd_applied", rd_state, E);
    set_state(4, S);
    do_snoop(5'b01010, 4, 1, 0, 1, 4, M, lat, fc, sh);
    verify("snoop_wins", 4, I, 1, 0, lat, fc, sh);
    set_state(12, M);
    do_snoop(5'b01100, 12, 1, 2, 2, 12, E, lat, fc, sh);
    verify("flush_overwrite", 12, S, 1, 3, lat, fc, sh);
    set_state(9, S);
    do_snoop(5'b00100, 9, 1, 0, 1, 9, E, lat, fc, sh);
    verify("nochange_keeps_local", 9, E, 0, 0, lat, fc, sh);
    set_state(14, S);
    loc_upd_valid = 1; loc_upd_index = 14; loc_upd_state = M; rd_index = 14; #1;
    chk("no_bypass", rd_state, S);
    @(negedge clk); loc_upd_valid = 0; #1;
    chk("local_write", rd_state, M);
    set_state(13, M); set_state(0, E);
    @(negedge clk);
    sif.snoop_valid = 1; sif.bus_signals = 5'b01010; sif.snoop_index = 13; sif.snoop_hit = 1; sif.flush_ack = 0;
    @(posedge clk); #1 sif.snoop_valid = 0;
    n = 0;
    while (!sif.flush_req && n < 10) begin @(negedge clk); n++; end
    chk("rst_mid_flush_seen", sif.flush_req, 1);
    rst = 1;
    @(negedge clk); rst = 0;
    chk("rst_mid_flush_req", sif.flush_req, 0);
    chk("rst_mid_ready", sif.snoop_ready, 1);
    chk("rst_mid_perr", protocol_err, 0);
    chk("rst_mid_done", sif.snoop_done, 0);
    nz = 0;
    for (int k = 0; k < 16; k++) begin
      rd_index = 4'(k);
      @(negedge clk);
      if (rd_state != I) nz++;
    end
    chk("rst_mid_table_clear", nz, 0);
    exp_perr = 0;
    for (int k = 0; k < 16; k++) model_tbl[k] = I;
    for (int it = 0; it < 250; it++) begin
      logic [3:0] ix;
      logic [1:0] e_nxt;
      logic [4:0] b;
      logic h, e_sh, fl, er;
      int d;
      ix = 4'($urandom);
      if ($urandom_range(0, 1) == 1) set_state(ix, 2'($urandom));
      b[4:3] = 2'($urandom);
      case ($urandom_range(0, 4))
        0: b[2:0] = 3'b100;
        1: b[2:0] = 3'b010;
        2: b[2:0] = 3'b001;
        default: b[2:0] = 3'($urandom);
      endcase
      h = $urandom_range(0, 3) != 0;
      d = $urandom_range(0, 3);
      ref_snoop(model_tbl[ix], b, h, e_nxt, e_sh, fl, er);
      do_snoop(b, ix, h, d, 0, 0, 0, lat, fc, sh);
      exp_perr |= er;
      model_tbl[ix] = e_nxt;
      verify($sformatf("rnd%0d", it), ix, e_nxt, e_sh, fl ? d + 1 : 0, lat, fc, sh);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
